// File: rtl/if_fetch_buffer_if.sv
// Fetch-stage bus: PC register hookup, instruction-memory handshake and decode-side head entry.
// The slave modport is the fetch buffer itself; master is whatever surrounds it.
interface if_fetch_buffer_if;
    logic [31:0] pc;
    logic        pc_we;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        flush;
    logic        id_ready;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;

    modport slave (
        input  pc, im_ack, im_rdata, flush, id_ready,
        output pc_we, im_req, im_addr, ir_valid, ir, ir_pc
    );

    modport master (
        output pc, im_ack, im_rdata, flush, id_ready,
        input  pc_we, im_req, im_addr, ir_valid, ir, ir_pc
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: issues one memory read at a time and queues the returned
// {pc, instr} pairs in a 4-entry FIFO that feeds decode.
//
// state | meaning
// IDLE  | no read outstanding; issues the next fetch when a FIFO slot is free
// WAIT  | read outstanding; its data will be pushed on im_ack
// DROP  | read outstanding but squashed by a flush; its data is discarded on im_ack
module if_fetch_buffer (
    input  logic clk,
    input  logic reset,
    if_fetch_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  count_q;
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [31:0] addr_q;
    logic [31:0] mem_pc [4];
    logic [31:0] mem_ir [4];

    logic        outstanding;
    logic [3:0]  pending;
    logic        issue, push, pop;
    logic        req, we;
    logic        head_valid;
    logic [31:0] fetch_addr;

    // A slot is reserved at issue time, so a push never sees a full FIFO.
    assign outstanding = (state_q != IDLE);
    assign pending     = {1'b0, count_q} + {3'b000, outstanding};
    assign fetch_addr  = {bus.pc[31:2], 2'b00};
    assign issue       = !reset && (state_q == IDLE) && !bus.flush && (pending < 4'd4);
    assign head_valid  = !reset && (count_q != 3'd0);

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        we      = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    req     = 1'b1;
                    we      = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.im_ack) begin
                    push    = !bus.flush;
                    state_d = IDLE;
                end else if (bus.flush) begin
                    state_d = DROP;
                end
            end
            // The ack retires the squashed read even if another flush arrives with it;
            // staying in DROP there would wait forever for an ack that never comes.
            DROP: begin
                if (bus.im_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) we = 1'b1;
        if (reset) begin
            req  = 1'b0;
            we   = 1'b0;
            push = 1'b0;
        end
    end

    assign pop = head_valid && bus.id_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 3'd0;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            addr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (issue) addr_q <= fetch_addr;
            if (bus.flush) begin
                count_q  <= 3'd0;
                rd_ptr_q <= 2'd0;
                wr_ptr_q <= 2'd0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
                count_q <= count_q + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q] <= addr_q;
            mem_ir[wr_ptr_q] <= bus.im_rdata;
        end
    end

    assign bus.im_req   = req;
    assign bus.pc_we    = we;
    assign bus.im_addr  = fetch_addr;
    assign bus.ir_valid = head_valid;
    assign bus.ir       = head_valid ? mem_ir[rd_ptr_q] : 32'd0;
    assign bus.ir_pc    = head_valid ? mem_pc[rd_ptr_q] : 32'd0;
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Fetch buffer bench: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue-based model of the fetch buffer.
module tb_if_fetch_buffer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_fetch_buffer_if bus();
    if_fetch_buffer dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: FIFO as a queue, plus "a read is outstanding" and "its data must be dropped".
    logic [63:0] q[$];
    bit          m_busy    = 1'b0;
    bit          m_discard = 1'b0;
    logic [31:0] m_addr    = 32'd0;
    logic [31:0] pc_reg    = 32'd0;

    logic        o_req, o_we, o_valid;
    logic [31:0] o_addr, o_ir, o_irpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit fl, input bit ack, input bit rdy,
                        input logic [31:0] rdata, input logic [31:0] target);
        bit          e_req, e_we, e_valid;
        logic [31:0] e_ir, e_irpc;
        reset        = rst;
        bus.flush    = fl;
        bus.im_ack   = ack;
        bus.id_ready = rdy;
        bus.im_rdata = rdata;
        bus.pc       = pc_reg;

        e_req   = !rst && !fl && !m_busy && (q.size() < 4);
        e_we    = !rst && (fl || e_req);
        e_valid = !rst && (q.size() != 0);
        e_ir    = e_valid ? q[0][31:0]  : 32'd0;
        e_irpc  = e_valid ? q[0][63:32] : 32'd0;

        @(negedge clk);
        o_req   = bus.im_req;
        o_we    = bus.pc_we;
        o_valid = bus.ir_valid;
        o_addr  = bus.im_addr;
        o_ir    = bus.ir;
        o_irpc  = bus.ir_pc;
        chk("im_req",   {31'd0, o_req},   {31'd0, e_req});
        chk("pc_we",    {31'd0, o_we},    {31'd0, e_we});
        chk("ir_valid", {31'd0, o_valid}, {31'd0, e_valid});
        chk("ir",       o_ir,   e_ir);
        chk("ir_pc",    o_irpc, e_irpc);
        if (e_req) chk("im_addr", o_addr, {pc_reg[31:2], 2'b00});

        @(posedge clk);
        if (rst) begin
            q.delete();
            m_busy    = 1'b0;
            m_discard = 1'b0;
            m_addr    = 32'd0;
        end else if (fl) begin
            q.delete();
            if (m_busy && ack) begin
                m_busy    = 1'b0;
                m_discard = 1'b0;
            end else if (m_busy) begin
                m_discard = 1'b1;
            end
            pc_reg = target;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (m_busy && ack) begin
                if (!m_discard) q.push_back({m_addr, rdata});
                m_busy    = 1'b0;
                m_discard = 1'b0;
            end
            if (e_req) begin
                m_busy = 1'b1;
                m_addr = {pc_reg[31:2], 2'b00};
                pc_reg = pc_reg + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        bus.pc = 32'd0; bus.im_ack = 1'b0; bus.im_rdata = 32'd0;
        bus.flush = 1'b0; bus.id_ready = 1'b0; reset = 1'b1;

        // Stream with immediate acks and consumption
        pc_reg = 32'h3000;
        step(1, 0, 0, 0, 0, 0);
        chk("rst_req", {31'd0, o_req}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, m_busy, 1, 32'h1000_0000 + i, 0);
            if (i == 0) chk("stream_addr0", o_addr, 32'h3000);
            if (i == 2) begin
                chk("stream_irpc0", o_irpc, 32'h3000);
                chk("stream_ir0", o_ir, 32'h1000_0001);
                chk("stream_addr1", o_addr, 32'h3004);
            end
            if (i == 4) chk("stream_addr2", o_addr, 32'h3008);
            if (i % 2 == 1) chk("stream_empty", {31'd0, o_valid}, 32'd0);
        end

        // Backpressure: fill to 4, then one pop releases one request
        pc_reg = 32'h3000;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, m_busy, 0, 32'h2000_0000 + i, 0);
        chk("full_req", {31'd0, o_req}, 32'd0);
        chk("full_we", {31'd0, o_we}, 32'd0);
        chk("full_irpc", o_irpc, 32'h3000);
        step(0, 0, 0, 1, 0, 0);
        chk("full_pop_req", {31'd0, o_req}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("refill_req", {31'd0, o_req}, 32'd1);
        chk("refill_addr", o_addr, 32'h3010);
        step(0, 0, 1, 0, 32'h2222_2222, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_full_ir", o_ir, 32'd0);
        chk("rst_full_irpc", o_irpc, 32'd0);

        // Simultaneous push and pop at count=2
        pc_reg = 32'h3000;
        for (int i = 0; i < 4; i++) step(0, 0, m_busy, 0, 32'h3000_0000 + i, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h3333_0002, 0);
        chk("pp_head_before", o_irpc, 32'h3000);
        step(0, 0, 0, 1, 0, 0);
        chk("pp_head_after", o_irpc, 32'h3004);
        step(0, 0, 0, 1, 0, 0);
        chk("pp_head_last", o_irpc, 32'h3008);
        chk("pp_ir_last", o_ir, 32'h3333_0002);
        step(0, 0, 0, 0, 0, 0);
        chk("pp_drained", {31'd0, o_valid}, 32'd0);

        // Flush while a read is outstanding
        pc_reg = 32'h3000;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, m_busy, 1, 32'h4000_0000 + i, 0);
        chk("fl_addr", o_addr, 32'h3008);
        step(0, 1, 0, 1, 0, 32'h8000);
        chk("fl_we", {31'd0, o_we}, 32'd1);
        chk("fl_req", {31'd0, o_req}, 32'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("drop_we", {31'd0, o_we}, 32'd0);
        step(0, 0, 1, 1, 32'hDEAD_BEEF, 0);
        chk("drop_ack_req", {31'd0, o_req}, 32'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("fl_discard", {31'd0, o_valid}, 32'd0);
        chk("fl_new_addr", o_addr, 32'h8000);
        chk("fl_new_req", {31'd0, o_req}, 32'd1);

        // Flush with three entries queued and decode ready
        pc_reg = 32'h3000;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, m_busy, 0, 32'h5000_0000 + i, 0);
        step(0, 1, 0, 1, 0, 32'h4000);
        chk("fl3_head", o_irpc, 32'h3000);
        step(0, 0, 0, 1, 0, 0);
        chk("fl3_ir", o_ir, 32'd0);
        chk("fl3_irpc", o_irpc, 32'd0);
        chk("fl3_addr", o_addr, 32'h4000);

        // Reset while waiting; the late ack must be ignored
        step(1, 0, 0, 0, 0, 0);
        chk("rw_req", {31'd0, o_req}, 32'd0);
        chk("rw_we", {31'd0, o_we}, 32'd0);
        step(0, 0, 1, 1, 32'hCAFE_F00D, 0);
        chk("rw_reissue", {31'd0, o_req}, 32'd1);
        chk("rw_addr", o_addr, 32'h4004);
        step(0, 0, 0, 1, 0, 0);
        chk("rw_nopush", {31'd0, o_valid}, 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                 $urandom(), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
